// File: rtl/prio_encode_pkg.sv
// Shared types and helpers for the registered priority / round-robin encoder.
package prio_encode_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  localparam int MAX_N = 64;

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Clearing the lowest set bit leaves something only if two or more bits were set.
  function automatic logic popcount_gt1(input logic [MAX_N-1:0] v);
    return (v & (v - 64'd1)) != '0;
  endfunction

endpackage

// File: rtl/prio_encode_rr_pick.sv
// Combinational index search: highest set bit, or first set bit at/above ptr with wrap.
module prio_pick
  import prio_encode_pkg::*;
#(
  parameter int N  = 8,
  parameter int RR = 0,
  parameter int W  = idx_w(N)
) (
  input  logic [N-1:0] vec,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] idx
);

  logic [N-1:0] hi;
  logic [W-1:0] hi_idx;
  logic [W-1:0] lo_idx;
  logic [W-1:0] top_idx;
  logic         unused_ptr;

  assign unused_ptr = ^ptr;

  always_comb begin
    hi      = '0;
    hi_idx  = '0;
    lo_idx  = '0;
    top_idx = '0;
    for (int i = 0; i < N; i++) begin
      hi[i] = vec[i] && (i >= int'(ptr));
      if (vec[i]) top_idx = W'(i);
    end
    // Descending scan so the last assignment is the lowest qualifying index.
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) lo_idx = W'(i);
      if (hi[i])  hi_idx = W'(i);
    end
  end

  always_comb begin
    idx = '0;
    if (RR == 0) idx = top_idx;
    else         idx = (|hi) ? hi_idx : lo_idx;
  end

endmodule

// File: rtl/prio_encode_rr.sv
// Registered N-bit request encoder with valid/ack handshake, fixed priority or round-robin.
module prio_encode_rr
  import prio_encode_pkg::*;
#(
  parameter int N  = 8,
  parameter int W  = idx_w(N),
  parameter int RR = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] x,
  input  logic         ack,
  output logic [W-1:0] y,
  output logic         valid,
  output logic         multi
);

  state_t       state_p1;
  logic [W-1:0] y_p1;
  logic         multi_p1;
  logic         vld_p1;
  logic [W-1:0] ptr_p1;

  logic         hs;
  logic         cap;
  logic [W-1:0] ptr_nxt;
  logic [W-1:0] pick_idx;
  logic         pick_multi;

  assign hs  = vld_p1 && ack;
  assign cap = en && (x != '0) && (!vld_p1 || ack);

  always_comb begin
    ptr_nxt = ptr_p1;
    if (hs && RR != 0)
      ptr_nxt = (y_p1 == W'(N - 1)) ? '0 : y_p1 + W'(1);
  end

  // A back-to-back capture searches from the already-advanced pointer.
  prio_pick #(.N(N), .RR(RR), .W(W)) u_pick (
    .vec (x),
    .ptr (ptr_nxt),
    .idx (pick_idx)
  );

  assign pick_multi = popcount_gt1(MAX_N'(x));

  // ---- stage p1: output and pointer registers ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p1 <= S_IDLE;
      vld_p1   <= 1'b0;
      y_p1     <= '0;
      multi_p1 <= 1'b0;
      ptr_p1   <= '0;
    end else begin
      case (state_p1)
        S_IDLE: begin
          if (cap) begin
            state_p1 <= S_HOLD;
            vld_p1   <= 1'b1;
            y_p1     <= pick_idx;
            multi_p1 <= pick_multi;
          end
        end
        S_HOLD: begin
          if (ack) begin
            ptr_p1 <= ptr_nxt;
            if (cap) begin
              y_p1     <= pick_idx;
              multi_p1 <= pick_multi;
            end else begin
              state_p1 <= S_IDLE;
              vld_p1   <= 1'b0;
              y_p1     <= '0;
              multi_p1 <= 1'b0;
            end
          end
        end
        default: begin
          state_p1 <= S_IDLE;
          vld_p1   <= 1'b0;
          y_p1     <= '0;
          multi_p1 <= 1'b0;
        end
      endcase
    end
  end

  assign y     = y_p1;
  assign valid = vld_p1;
  assign multi = multi_p1;

endmodule

// File: tb/tb_prio_encode_rr.sv
// Directed bench for prio_encode_rr: fixed priority, round-robin N=8 and round-robin N=5.
module tb_prio_encode_rr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int chk = 0;
  int err = 0;

  // fixed priority, N=8
  logic       rst0, en0, ack0;
  logic [7:0] x0;
  logic [2:0] y0;
  logic       v0, m0;
  // round-robin, N=8
  logic       rst1, en1, ack1;
  logic [7:0] x1;
  logic [2:0] y1;
  logic       v1, m1;
  // round-robin, N=5
  logic       rst5, en5, ack5;
  logic [4:0] x5;
  logic [2:0] y5;
  logic       v5, m5;

  prio_encode_rr #(.N(8), .RR(0)) u_fp (
    .clk(clk), .rst(rst0), .en(en0), .x(x0), .ack(ack0),
    .y(y0), .valid(v0), .multi(m0)
  );

  prio_encode_rr #(.N(8), .RR(1)) u_rr (
    .clk(clk), .rst(rst1), .en(en1), .x(x1), .ack(ack1),
    .y(y1), .valid(v1), .multi(m1)
  );

  prio_encode_rr #(.N(5), .RR(1)) u_r5 (
    .clk(clk), .rst(rst5), .en(en5), .x(x5), .ack(ack5),
    .y(y5), .valid(v5), .multi(m5)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rst_all();
    rst0 = 1'b1; rst1 = 1'b1; rst5 = 1'b1;
    en0 = 1'b0; en1 = 1'b0; en5 = 1'b0;
    ack0 = 1'b0; ack1 = 1'b0; ack5 = 1'b0;
    x0 = '0; x1 = '0; x5 = '0;
    tick();
    rst0 = 1'b0; rst1 = 1'b0; rst5 = 1'b0;
  endtask

  task automatic test_reset();
    rst0 = 1'b1; rst1 = 1'b1; rst5 = 1'b1;
    en0 = 1'b1; en1 = 1'b1; en5 = 1'b1;
    ack0 = 1'b0; ack1 = 1'b0; ack5 = 1'b0;
    x0 = 8'hFF; x1 = 8'hFF; x5 = 5'h1F;
    tick();
    tick();
    chk++; if (y0 !== 3'd0) begin err++; $display("FAIL reset_y_fp got %0d want 0", y0); end
    chk++; if (v0 !== 1'b0) begin err++; $display("FAIL reset_valid_fp got %b want 0", v0); end
    chk++; if (m0 !== 1'b0) begin err++; $display("FAIL reset_multi_fp got %b want 0", m0); end
    chk++; if (y1 !== 3'd0) begin err++; $display("FAIL reset_y_rr got %0d want 0", y1); end
    chk++; if (v1 !== 1'b0) begin err++; $display("FAIL reset_valid_rr got %b want 0", v1); end
    chk++; if (m1 !== 1'b0) begin err++; $display("FAIL reset_multi_rr got %b want 0", m1); end
    chk++; if (v5 !== 1'b0) begin err++; $display("FAIL reset_valid_r5 got %b want 0", v5); end
    rst0 = 1'b0; rst1 = 1'b0; rst5 = 1'b0;
    en0 = 1'b0; en5 = 1'b0;
    tick();
    chk++; if (y1 !== 3'd0) begin err++; $display("FAIL reset_first_rr_y got %0d want 0", y1); end
    chk++; if (v1 !== 1'b1) begin err++; $display("FAIL reset_first_rr_valid got %b want 1", v1); end
    chk++; if (m1 !== 1'b1) begin err++; $display("FAIL reset_first_rr_multi got %b want 1", m1); end
  endtask

  task automatic test_fixed_hold();
    rst_all();
    x0 = 8'b0010_0100; en0 = 1'b1;
    tick();
    chk++; if (y0 !== 3'd5) begin err++; $display("FAIL fixed_y got %0d want 5", y0); end
    chk++; if (v0 !== 1'b1) begin err++; $display("FAIL fixed_valid got %b want 1", v0); end
    chk++; if (m0 !== 1'b1) begin err++; $display("FAIL fixed_multi got %b want 1", m0); end
    x0 = 8'h01;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk++; if (y0 !== 3'd5 || v0 !== 1'b1 || m0 !== 1'b1)
        begin err++; $display("FAIL hold_frozen cyc %0d got y=%0d v=%b m=%b want y=5 v=1 m=1", i, y0, v0, m0); end
    end
    ack0 = 1'b1;
    tick();
    chk++; if (y0 !== 3'd0) begin err++; $display("FAIL b2b_fixed_y got %0d want 0", y0); end
    chk++; if (v0 !== 1'b1) begin err++; $display("FAIL b2b_fixed_valid got %b want 1", v0); end
    chk++; if (m0 !== 1'b0) begin err++; $display("FAIL b2b_fixed_multi got %b want 0", m0); end
    ack0 = 1'b0; en0 = 1'b0;
    tick();
    chk++; if (v0 !== 1'b1) begin err++; $display("FAIL hold_no_ack_valid got %b want 1", v0); end
    ack0 = 1'b1;
    tick();
    chk++; if (v0 !== 1'b0 || y0 !== 3'd0 || m0 !== 1'b0)
      begin err++; $display("FAIL ack_to_idle got v=%b y=%0d m=%b want v=0 y=0 m=0", v0, y0, m0); end
    ack0 = 1'b0;
  endtask

  task automatic test_rr_fairness();
    rst_all();
    x1 = 8'hFF; en1 = 1'b1;
    tick();
    chk++; if (y1 !== 3'd0 || v1 !== 1'b1) begin err++; $display("FAIL rr_first got y=%0d v=%b want y=0 v=1", y1, v1); end
    ack1 = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk++; if (y1 !== 3'(k % 8) || v1 !== 1'b1)
        begin err++; $display("FAIL rr_seq step %0d got y=%0d v=%b want y=%0d v=1", k, y1, v1, k % 8); end
    end
    en1 = 1'b0;
    tick();
    chk++; if (v1 !== 1'b0) begin err++; $display("FAIL rr_release got %b want 0", v1); end
    ack1 = 1'b0;
  endtask

  task automatic test_wrap();
    rst_all();
    x1 = 8'h40; en1 = 1'b1;
    x5 = 5'b10000; en5 = 1'b1;
    tick();
    chk++; if (y1 !== 3'd6) begin err++; $display("FAIL wrap8_grant got %0d want 6", y1); end
    chk++; if (y5 !== 3'd4) begin err++; $display("FAIL wrap5_grant got %0d want 4", y5); end
    chk++; if (m5 !== 1'b0) begin err++; $display("FAIL wrap5_multi got %b want 0", m5); end
    x1 = 8'h41; ack1 = 1'b1;
    x5 = 5'b10001; ack5 = 1'b1;
    tick();
    chk++; if (y1 !== 3'd0 || v1 !== 1'b1) begin err++; $display("FAIL wrap8_next got y=%0d v=%b want y=0 v=1", y1, v1); end
    chk++; if (y5 !== 3'd0 || v5 !== 1'b1) begin err++; $display("FAIL wrap5_next got y=%0d v=%b want y=0 v=1", y5, v5); end
    chk++; if (m5 !== 1'b1) begin err++; $display("FAIL wrap5_next_multi got %b want 1", m5); end
    en1 = 1'b0; en5 = 1'b0;
    tick();
    ack1 = 1'b0; ack5 = 1'b0;
  endtask

  task automatic test_idle_guards();
    rst_all();
    x0 = 8'h80; en0 = 1'b0;
    tick();
    tick();
    chk++; if (v0 !== 1'b0 || y0 !== 3'd0) begin err++; $display("FAIL guard_en0 got v=%b y=%0d want v=0 y=0", v0, y0); end
    x0 = 8'h00; en0 = 1'b1;
    tick();
    chk++; if (v0 !== 1'b0) begin err++; $display("FAIL guard_x0 got %b want 0", v0); end
    en0 = 1'b0;
    ack1 = 1'b1; en1 = 1'b0; x1 = 8'h00;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk++; if (v1 !== 1'b0) begin err++; $display("FAIL guard_idle_ack cyc %0d got %b want 0", i, v1); end
    end
    ack1 = 1'b0; x1 = 8'hFF; en1 = 1'b1;
    tick();
    chk++; if (y1 !== 3'd0 || v1 !== 1'b1) begin err++; $display("FAIL guard_ptr_kept got y=%0d v=%b want y=0 v=1", y1, v1); end
    en1 = 1'b0; ack1 = 1'b1;
    tick();
    ack1 = 1'b0;
  endtask

  task automatic test_reset_mid_hold();
    rst_all();
    x1 = 8'hFF; en1 = 1'b1;
    tick();
    x1 = 8'h08; ack1 = 1'b1;
    tick();
    chk++; if (y1 !== 3'd3 || v1 !== 1'b1) begin err++; $display("FAIL midhold_setup got y=%0d v=%b want y=3 v=1", y1, v1); end
    ack1 = 1'b0; rst1 = 1'b1; x1 = 8'hFF;
    tick();
    chk++; if (v1 !== 1'b0 || y1 !== 3'd0 || m1 !== 1'b0)
      begin err++; $display("FAIL midhold_reset got v=%b y=%0d m=%b want v=0 y=0 m=0", v1, y1, m1); end
    rst1 = 1'b0;
    tick();
    chk++; if (y1 !== 3'd0 || v1 !== 1'b1) begin err++; $display("FAIL midhold_ptr_cleared got y=%0d v=%b want y=0 v=1", y1, v1); end
    en1 = 1'b0; ack1 = 1'b1;
    tick();
    ack1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fixed_hold();
    test_rr_fairness();
    test_wrap();
    test_idle_guards();
    test_reset_mid_hold();
    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end

endmodule
